// File: rtl/serial_comparator_multibit.sv
// serial_comparator_multibit
//
// Compares two unsigned or two's-complement words that arrive serially as
// DIGIT_W-bit digits, WORD_LEN digits per word. The digit order (MSB-first or
// LSB-first) and the signedness are chosen per word. One registered one-hot
// verdict is produced per word, flagged by a single-cycle res_valid pulse.
//
// Parameters
//   DIGIT_W      bits per digit (>= 1)
//   WORD_LEN     digits per word (>= 2)
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   clear        synchronous abort of the word in progress (wins over in_valid)
//   msb_first    1: first digit is most significant, 0: least significant
//   signed_mode  1: operands are two's complement
//   in_valid     digit pair on a/b is accepted this cycle
//   a, b         current digit of operand A / operand B
//   busy         a word is partially received
//   res_valid    one-cycle pulse, verdict outputs were just updated
//   a_less_b     registered verdict A < B
//   a_eq_b       registered verdict A == B
//   a_greater_b  registered verdict A > B

module serial_comparator_multibit #(
  parameter int unsigned DIGIT_W  = 1,
  parameter int unsigned WORD_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               msb_first,
  input  logic               signed_mode,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               busy,
  output logic               res_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b
);

  localparam int unsigned CntW = (WORD_LEN > 2) ? $clog2(WORD_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_LEN - 1);

  // Digit position within the current word
  logic [CntW-1:0] cnt_q, cnt_d;

  // Modes latched on digit 0 and held for the rest of the word
  logic msb_q, msb_d;
  logic sgn_q, sgn_d;

  // Per-word partial state. MSB-first uses decided/lt, LSB-first uses lt/gt.
  logic decided_q, decided_d;
  logic lt_q, lt_d;
  logic gt_q, gt_d;

  // Registered outputs
  logic res_valid_q, res_valid_d;
  logic less_q, less_d;
  logic eq_q, eq_d;
  logic greater_q, greater_d;

  // Combinational helpers for the digit currently on the inputs
  logic               first_digit;
  logic               last_digit;
  logic               msb_eff;
  logic               sgn_eff;
  logic               ms_digit;
  logic [DIGIT_W-1:0] a_fix;
  logic [DIGIT_W-1:0] b_fix;
  logic               dig_lt;
  logic               dig_ne;
  logic               v_lt;
  logic               v_gt;

  assign first_digit = (cnt_q == '0);
  assign last_digit  = (cnt_q == LastCnt);

  // On digit 0 the modes come straight from the inputs; afterwards the
  // latched copies apply so mid-word changes are ignored.
  assign msb_eff = first_digit ? msb_first   : msb_q;
  assign sgn_eff = first_digit ? signed_mode : sgn_q;

  // The most significant digit is the first one in MSB-first order and the
  // last one in LSB-first order.
  assign ms_digit = msb_eff ? first_digit : last_digit;

  // Offset-binary trick: flipping the sign bit of both operands turns a
  // two's-complement compare into an unsigned one.
  always_comb begin
    a_fix = a;
    b_fix = b;
    if (sgn_eff && ms_digit) begin
      a_fix[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_fix[DIGIT_W-1] = ~b[DIGIT_W-1];
    end
  end

  assign dig_lt = (a_fix < b_fix);
  assign dig_ne = (a_fix != b_fix);

  // Verdict for a word whose final digit is on the inputs this cycle
  always_comb begin
    v_lt = 1'b0;
    v_gt = 1'b0;
    if (msb_eff) begin
      // Earliest differing digit dominates
      if (decided_q) begin
        v_lt = lt_q;
        v_gt = ~lt_q;
      end else begin
        v_lt = dig_lt;
        v_gt = dig_ne & ~dig_lt;
      end
    end else begin
      // Latest differing digit dominates, and the final digit is the MS one
      if (dig_ne) begin
        v_lt = dig_lt;
        v_gt = ~dig_lt;
      end else begin
        v_lt = lt_q;
        v_gt = gt_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d       = cnt_q;
    msb_d       = msb_q;
    sgn_d       = sgn_q;
    decided_d   = decided_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    res_valid_d = 1'b0;
    less_d      = less_q;
    eq_d        = eq_q;
    greater_d   = greater_q;

    if (clear) begin
      // Abort: drop the partial word, leave the last verdict untouched
      cnt_d     = '0;
      decided_d = 1'b0;
      lt_d      = 1'b0;
      gt_d      = 1'b0;
    end else if (in_valid) begin
      if (first_digit) begin
        msb_d = msb_first;
        sgn_d = signed_mode;
      end

      if (last_digit) begin
        // Final digit: register the verdict and start the next word clean
        cnt_d       = '0;
        decided_d   = 1'b0;
        lt_d        = 1'b0;
        gt_d        = 1'b0;
        res_valid_d = 1'b1;
        less_d      = v_lt;
        greater_d   = v_gt;
        eq_d        = ~v_lt & ~v_gt;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        if (msb_eff) begin
          if (!decided_q && dig_ne) begin
            decided_d = 1'b1;
            lt_d      = dig_lt;
          end
        end else if (dig_ne) begin
          lt_d = dig_lt;
          gt_d = ~dig_lt;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      msb_q       <= 1'b0;
      sgn_q       <= 1'b0;
      decided_q   <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      res_valid_q <= 1'b0;
      less_q      <= 1'b0;
      eq_q        <= 1'b1;
      greater_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      msb_q       <= msb_d;
      sgn_q       <= sgn_d;
      decided_q   <= decided_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      res_valid_q <= res_valid_d;
      less_q      <= less_d;
      eq_q        <= eq_d;
      greater_q   <= greater_d;
    end
  end

  assign busy        = (cnt_q != '0);
  assign res_valid   = res_valid_q;
  assign a_less_b    = less_q;
  assign a_eq_b      = eq_q;
  assign a_greater_b = greater_q;

endmodule

// File: tb/tb_serial_comparator_multibit.sv
module tb_serial_comparator_multibit;

  logic clk = 1'b0;
  logic rst;

  // 4-bit digit, 4-digit instance
  logic       clr4, msb4, sgn4, in4;
  logic [3:0] a4, b4;
  logic       busy4, rv4, lt4, eq4, gt4;

  // 1-bit digit, 16-digit instance
  logic       clr1, msb1, sgn1, in1;
  logic [0:0] a1, b1;
  logic       busy1, rv1, lt1, eq1, gt1;

  int n_checks = 0;
  int n_pass   = 0;
  int rv4_cnt  = 0;
  int snap;

  always #5 clk = ~clk;

  always @(negedge clk) if (rv4) rv4_cnt++;

  serial_comparator_multibit #(.DIGIT_W(4), .WORD_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clr4), .msb_first(msb4), .signed_mode(sgn4),
    .in_valid(in4), .a(a4), .b(b4), .busy(busy4), .res_valid(rv4),
    .a_less_b(lt4), .a_eq_b(eq4), .a_greater_b(gt4)
  );

  serial_comparator_multibit #(.DIGIT_W(1), .WORD_LEN(16)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clr1), .msb_first(msb1), .signed_mode(sgn1),
    .in_valid(in1), .a(a1), .b(b1), .busy(busy1), .res_valid(rv1),
    .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic digit4(input logic [3:0] da, input logic [3:0] db);
    a4  = da;
    b4  = db;
    in4 = 1'b1;
    step();
    in4 = 1'b0;
  endtask

  task automatic send4(input logic [15:0] wa, input logic [15:0] wb, input logic m,
                       input logic s);
    int idx;
    msb4 = m;
    sgn4 = s;
    for (int i = 0; i < 4; i++) begin
      idx = m ? (3 - i) : i;
      digit4(wa[idx*4 +: 4], wb[idx*4 +: 4]);
    end
  endtask

  initial begin
    logic [15:0] wa1;
    logic [15:0] wb1;
    rst  = 1'b1;
    clr4 = 0; msb4 = 0; sgn4 = 0; in4 = 0; a4 = '0; b4 = '0;
    clr1 = 0; msb1 = 0; sgn1 = 0; in1 = 0; a1 = '0; b1 = '0;
    step();
    step();
    chk("rst4_verdict", {lt4, eq4, gt4}, 3'b010);
    chk("rst4_rv_busy", {rv4, busy4}, 2'b00);
    chk("rst1_verdict", {lt1, eq1, gt1}, 3'b010);
    rst = 1'b0;
    step();

    // 1: unsigned MSB-first 0x6482 vs 0x6262
    send4(16'h6482, 16'h6262, 1'b1, 1'b0);
    chk("t1_rv", rv4, 1'b1);
    chk("t1_verdict", {lt4, eq4, gt4}, 3'b001);
    step();
    chk("t1_rv_drop", rv4, 1'b0);
    chk("t1_hold", {lt4, eq4, gt4}, 3'b001);

    // 2: same operands LSB-first, then equal word with an idle gap
    send4(16'h6482, 16'h6262, 1'b0, 1'b0);
    chk("t2_lsb_verdict", {rv4, lt4, eq4, gt4}, 4'b1001);
    step();
    snap = rv4_cnt;
    msb4 = 1'b1;
    digit4(4'h1, 4'h1);
    chk("t2_busy", busy4, 1'b1);
    repeat (3) step();
    msb4 = 1'b0; // mid-word mode change must be ignored
    digit4(4'h2, 4'h2);
    digit4(4'h3, 4'h3);
    digit4(4'h4, 4'h4);
    chk("t2_eq", {rv4, lt4, eq4, gt4}, 4'b1010);
    repeat (3) step();
    chk("t2_one_pulse", rv4_cnt - snap, 1);

    // 3: 0x8000 vs 0x0001, signed and unsigned, both orders
    send4(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("t3_msb_signed", {lt4, eq4, gt4}, 3'b100);
    send4(16'h8000, 16'h0001, 1'b1, 1'b0);
    chk("t3_msb_unsigned", {lt4, eq4, gt4}, 3'b001);
    send4(16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("t3_lsb_signed", {lt4, eq4, gt4}, 3'b100);
    send4(16'h8000, 16'h0001, 1'b0, 1'b0);
    chk("t3_lsb_unsigned", {lt4, eq4, gt4}, 3'b001);
    step();

    // 4: abort after two digits, then a fresh word
    snap = rv4_cnt;
    msb4 = 1'b1;
    sgn4 = 1'b0;
    digit4(4'hF, 4'h0);
    digit4(4'hF, 4'h0);
    chk("t4_busy", busy4, 1'b1);
    clr4 = 1'b1;
    a4 = 4'hF; b4 = 4'h0; in4 = 1'b1;
    step();
    clr4 = 1'b0;
    in4  = 1'b0;
    chk("t4_cleared", {busy4, rv4}, 2'b00);
    chk("t4_held", {lt4, eq4, gt4}, 3'b001);
    step();
    chk("t4_no_pulse", rv4_cnt - snap, 0);
    send4(16'h0001, 16'h0002, 1'b1, 1'b0);
    chk("t4_less", {rv4, lt4, eq4, gt4}, 4'b1100);

    // 5: asynchronous reset mid-word
    step();
    send4(16'h0001, 16'h0002, 1'b1, 1'b0);
    step();
    digit4(4'h9, 4'h1);
    digit4(4'h9, 4'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_async", {busy4, rv4, lt4, eq4, gt4}, 5'b00010);
    #2;
    rst = 1'b0;
    step();
    send4(16'h00FF, 16'h0100, 1'b1, 1'b0);
    chk("t5_after", {rv4, lt4, eq4, gt4}, 4'b1100);

    // 6: 1-bit digits, 16-digit words back-to-back, edges counted from here
    wa1  = 16'b0110_0100_1000_0010;
    wb1  = 16'b0110_0010_0110_0010;
    msb1 = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      in1 = (k <= 32);
      a1  = wa1[15 - ((k - 1) % 16)];
      b1  = wb1[15 - ((k - 1) % 16)];
      step();
      chk($sformatf("t6_rv_cycle%0d", k + 1), rv1, (k == 16 || k == 32));
      if (k == 16 || k == 32) chk("t6_verdict", {lt1, eq1, gt1}, 3'b001);
    end
    in1 = 1'b0;
    chk("t6_busy", busy1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
